instr_fetch: RTL

- Instruction-fetch initiator that sits in front of the synchronous instruction memory. The memory has a 1-cycle registered read, addressed by byte address with word index address[31:2].
- Generates the PC stream and tracks the in-flight read. Captures returned words into a small skid FIFO.
- Presents {instruction, PC} to decode with a valid/ready handshake. Supports branch redirect with flush.

---
 rtl/instr_fetch.sv | 91 +++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction-fetch front end: drives a 1-cycle synchronous instruction memory,
// tracks the outstanding read and buffers returned words for decode.
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W + 1)'(FIFO_DEPTH);

  logic [31:0]      pc_q;
  logic [31:0]      inflight_pc;
  logic             inflight_v;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [31:0]      fifo_pc    [FIFO_DEPTH];
  logic [31:0]      fifo_instr [FIFO_DEPTH];

  logic             pop;
  logic             push;
  logic             issue;
  logic [CNT_W:0]   occupancy;
  logic [31:0]      redirect_target;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign out_valid       = (count != '0);
  assign pop             = out_valid & out_ready;
  assign push            = inflight_v & ~redirect_valid;
  assign redirect_target = redirect_pc & ~32'h0000_0003;
  assign imem_addr       = pc_q;
  assign out_pc          = fifo_pc[rd_ptr];
  assign out_instr       = fifo_instr[rd_ptr];

  // A slot is reserved for every outstanding read, so the buffer cannot overflow.
  assign occupancy = {1'b0, count}
                   + {{CNT_W{1'b0}}, inflight_v}
                   - {{CNT_W{1'b0}}, pop};
  assign issue     = fetch_en & ~redirect_valid & (occupancy < DEPTH_EXT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      inflight_v  <= 1'b0;
      inflight_pc <= RESET_PC;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else if (redirect_valid) begin
      pc_q        <= redirect_target;
      inflight_v  <= 1'b0;
      inflight_pc <= pc_q;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count       <= count + CNT_W'(push) - CNT_W'(pop);
      inflight_v  <= issue;
      inflight_pc <= pc_q;
      if (issue) pc_q <= pc_q + 32'd4;
    end
  end

  // Storage needs no reset; validity is tracked entirely by count and the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= inflight_pc;
      fifo_instr[wr_ptr] <= imem_instr;
    end
  end

endmodule
